// File: rtl/clock_set_ctrl_pkg.sv
// clock_pkg: shared types and helpers for the digital-clock blocks.
//   set_state_e  - set-mode FSM states; the encoding doubles as the field select
//   field_t      - field-select bus shared with the counter and display blocks
//   FIELD_*      - field-select constants
//   ms_to_cycles - ms -> clk cycles in 64-bit arithmetic, floored at 2
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } set_state_e;

   typedef logic [1:0] field_t;

   localparam field_t FIELD_NONE = 2'd0;
   localparam field_t FIELD_HOUR = 2'd1;
   localparam field_t FIELD_MIN  = 2'd2;
   localparam field_t FIELD_SEC  = 2'd3;

   // freq*ms overflows 32 bits for realistic clocks; a count below 2 would
   // break the "terminal count minus one" compares downstream.
   function automatic longint unsigned ms_to_cycles(input longint unsigned freq_hz,
                                                    input longint unsigned ms);
      longint unsigned c;
      c = (freq_hz * ms) / 64'd1000;
      return (c < 64'd2) ? 64'd2 : c;
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: button inputs and control outputs of the set controller.
//   i_btn_mode/up/down - debounced button levels, active-high
//   o_sel              - selected field (FIELD_*)
//   o_inc/o_dec        - one-cycle strobes for field o_sel
//   o_run              - timekeeping enable
//   o_blink            - blink phase for the selected field
// master: the side driving buttons; slave: clock_set_ctrl.
interface clock_set_ctrl_if;
   import clock_pkg::*;

   logic   i_btn_mode;
   logic   i_btn_up;
   logic   i_btn_down;
   field_t o_sel;
   logic   o_inc;
   logic   o_dec;
   logic   o_run;
   logic   o_blink;

   modport master (output i_btn_mode, i_btn_up, i_btn_down,
                   input  o_sel, o_inc, o_dec, o_run, o_blink);
   modport slave  (input  i_btn_mode, i_btn_up, i_btn_down,
                   output o_sel, o_inc, o_dec, o_run, o_blink);
endinterface

// File: rtl/clock_set_ctrl_btn.sv
// btn_repeat: press detect and optional hold/auto-repeat for one button.
//   clk, rst_n - clock, async active-low reset
//   i_btn      - debounced level
//   i_enable   - pulses allowed (set state active)
//   i_clear    - kill pulse and hold count this cycle (MODE press / both held)
//   o_pulse    - combinational pulse; the parent registers it
// Build option AUTO_REPEAT_EN: when defined, a held button repeats after
// LONG_CNT cycles and then every REP_CNT cycles; otherwise one pulse per press.
module btn_repeat #(
   parameter int unsigned LONG_CNT = 2,
   parameter int unsigned REP_CNT  = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_pulse
);

   logic prev_q;
   logic lock_q, lock_d;
   logic press, active;

   assign press = i_btn & ~prev_q;

   // A button held while cleared or disabled stays dead until released, so
   // releasing the other button (or leaving run) never fakes a new press.
   always_comb begin
      lock_d = lock_q;
      if (!i_btn)                    lock_d = 1'b0;
      else if (i_clear || !i_enable) lock_d = 1'b1;
   end

   assign active = i_btn & i_enable & ~i_clear & ~lock_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b1;   // held-through-reset button needs a re-press
         lock_q <= 1'b0;
      end else begin
         prev_q <= i_btn;
         lock_q <= lock_d;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int unsigned MAXC = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
   localparam int unsigned CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] LONG_C = CW'(LONG_CNT);
   localparam logic [CW-1:0] REP_C  = CW'(REP_CNT);

   // cnt_q = cycles since the last pulse; rep_q = first repeat already given
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rep_q, rep_d;

   always_comb begin
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      o_pulse = 1'b0;
      if (!active) begin
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (press || cnt_q == (rep_q ? REP_C : LONG_C)) begin
         o_pulse = 1'b1;
         cnt_d   = CW'(1);
         rep_d   = ~press;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rep_q <= rep_d;
      end
   end
`else
   assign o_pulse = active & press;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: set-mode controller for the digital clock.
//   clk, rst_n - clock, async active-low reset
//   bus        - clock_set_ctrl_if.slave (buttons in, sel/inc/dec/run/blink out)
// MODE cycles run -> hour -> minute -> second -> run. UP/DOWN strobe the
// selected field. Inactivity in a set state falls back to run. Long-press
// auto-repeat is built only with AUTO_REPEAT_EN defined.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ    = 50_000_000,
   parameter int unsigned LONG_PRESS_ms = 1000,
   parameter int unsigned REPEAT_ms     = 200,
   parameter int unsigned TIMEOUT_s     = 10,
   parameter int unsigned BLINK_ms      = 500
) (
   input  logic             clk,
   input  logic             rst_n,
   clock_set_ctrl_if.slave  bus
);

   localparam longint unsigned FREQ        = longint'(CLOCK_FREQ);
   localparam longint unsigned LONG_CNT    = ms_to_cycles(FREQ, longint'(LONG_PRESS_ms));
   localparam longint unsigned REP_CNT     = ms_to_cycles(FREQ, longint'(REPEAT_ms));
   localparam longint unsigned TIMEOUT_CNT = ms_to_cycles(FREQ, longint'(TIMEOUT_s) * 64'd1000);
   localparam longint unsigned BLINK_CNT   = ms_to_cycles(FREQ, longint'(BLINK_ms));
   localparam int unsigned     TW          = $clog2(TIMEOUT_CNT);
   localparam int unsigned     BW          = $clog2(BLINK_CNT);
   localparam logic [TW-1:0]   TO_MAX      = TW'(TIMEOUT_CNT - 64'd1);
   localparam logic [BW-1:0]   BL_MAX      = BW'(BLINK_CNT - 64'd1);

   set_state_e    state_q, state_d;
   logic          mode_prev_q, mode_press;
   logic [TW-1:0] to_q, to_d;
   logic [BW-1:0] bl_q, bl_d;
   logic          blink_q, blink_d;
   logic          inc_q, dec_q, run_q;
   logic          in_set, both, clr, up_pulse, dn_pulse, any_pulse, chg;

   assign mode_press = bus.i_btn_mode & ~mode_prev_q;
   assign in_set     = (state_q != ST_RUN);
   assign both       = bus.i_btn_up & bus.i_btn_down;
   assign clr        = mode_press | both;
   assign any_pulse  = up_pulse | dn_pulse;

   btn_repeat #(.LONG_CNT(int'(LONG_CNT)), .REP_CNT(int'(REP_CNT))) u_up (
      .clk(clk), .rst_n(rst_n), .i_btn(bus.i_btn_up), .i_enable(in_set),
      .i_clear(clr), .o_pulse(up_pulse));

   btn_repeat #(.LONG_CNT(int'(LONG_CNT)), .REP_CNT(int'(REP_CNT))) u_dn (
      .clk(clk), .rst_n(rst_n), .i_btn(bus.i_btn_down), .i_enable(in_set),
      .i_clear(clr), .o_pulse(dn_pulse));

   always_comb begin
      state_d = state_q;
      to_d    = to_q;
      bl_d    = bl_q;
      blink_d = blink_q;
      if (mode_press) begin
         case (state_q)
            ST_RUN:     state_d = ST_SET_HR;
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_SEC;
            default:    state_d = ST_RUN;
         endcase
      end else if (in_set && !any_pulse && to_q == TO_MAX) begin
         state_d = ST_RUN;   // a pulse in the last cycle wins over the timeout
      end
      chg = (state_d != state_q);

      if (!in_set || any_pulse || chg) to_d = '0;
      else                             to_d = to_q + TW'(1);

      // blink phase restarts low on every state change and stays low in run
      if (chg || state_d == ST_RUN) begin
         bl_d    = '0;
         blink_d = 1'b0;
      end else if (bl_q == BL_MAX) begin
         bl_d    = '0;
         blink_d = ~blink_q;
      end else begin
         bl_d    = bl_q + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         mode_prev_q <= 1'b1;
         to_q        <= '0;
         bl_q        <= '0;
         blink_q     <= 1'b0;
         inc_q       <= 1'b0;
         dec_q       <= 1'b0;
         run_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         mode_prev_q <= bus.i_btn_mode;
         to_q        <= to_d;
         bl_q        <= bl_d;
         blink_q     <= blink_d;
         inc_q       <= up_pulse & ~chg;
         dec_q       <= dn_pulse & ~chg;
         run_q       <= (state_d == ST_RUN);
      end
   end

   assign bus.o_sel   = field_t'(state_q);
   assign bus.o_inc   = inc_q;
   assign bus.o_dec   = dec_q;
   assign bus.o_run   = run_q;
   assign bus.o_blink = blink_q;

endmodule
